// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use/branch stall-flush control, EX operand forwarding,
// and the data-memory wait handshake with a timeout that latches a sticky error.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic [4:0] rs1_e,
  input  logic [4:0] rs2_e,
  input  logic [4:0] destinationReg_e,
  input  logic       memRead_e,
  input  logic       pcSrc_e,
  input  logic [4:0] destinationReg_m,
  input  logic       regWrite_m,
  input  logic       memAccess_m,
  input  logic [4:0] destinationReg_w,
  input  logic       regWrite_w,
  input  logic       dmem_ready,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_x,
  output logic       flush_d,
  output logic       flush_e,
  output logic       flush_w,
  output logic [1:0] forwardA_e,
  output logic [1:0] forwardB_e,
  output logic       dmem_req,
  output logic       mem_err
);

  // Counter must hold MEM_TIMEOUT itself; a zero timeout still needs one bit.
  localparam int CW       = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int LAST_I   = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAST_I);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  // state    | meaning
  // RUN      | normal issue, no memory wait pending
  // MEM_WAIT | data access outstanding, pipeline frozen
  // ERROR    | memory timed out, pipeline frozen until reset
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          mem_err_q, mem_err_d;

  logic mem_stall;
  logic load_use;
  logic timeout_hit;

  assign dmem_req  = memAccess_m && (state_q != ERROR) && !rst;
  assign mem_stall = dmem_req && !dmem_ready;
  assign load_use  = memRead_e && (destinationReg_e != 5'd0) &&
                     ((destinationReg_e == rs1_d) || (destinationReg_e == rs2_d));
  assign timeout_hit = (MEM_TIMEOUT != 0) && mem_stall && (wait_cnt_q == CNT_LAST);
  assign mem_err   = mem_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    mem_err_d  = mem_err_q;

    // Saturating so a disabled timeout can never wrap back to zero.
    if (mem_stall) begin
      wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CW'(1);
    end

    case (state_q)
      RUN: begin
        if (timeout_hit) begin
          state_d   = ERROR;
          mem_err_d = 1'b1;
        end else if (mem_stall) begin
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (timeout_hit) begin
          state_d   = ERROR;
          mem_err_d = 1'b1;
        end else if (!mem_stall) begin
          state_d = RUN;
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    forwardA_e = 2'b00;
    forwardB_e = 2'b00;
    if (!rst) begin
      if (regWrite_m && (destinationReg_m != 5'd0) && (destinationReg_m == rs1_e)) begin
        forwardA_e = 2'b10;
      end else if (regWrite_w && (destinationReg_w != 5'd0) && (destinationReg_w == rs1_e)) begin
        forwardA_e = 2'b01;
      end
      if (regWrite_m && (destinationReg_m != 5'd0) && (destinationReg_m == rs2_e)) begin
        forwardB_e = 2'b10;
      end else if (regWrite_w && (destinationReg_w != 5'd0) && (destinationReg_w == rs2_e)) begin
        forwardB_e = 2'b01;
      end
    end
  end

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_x = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;

    if (rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else if ((state_q == ERROR) || mem_stall) begin
      // A pending branch stays in EX and is honoured on the release cycle.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_x = 1'b1;
      flush_w = 1'b1;
    end else if (pcSrc_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scenario bench for hazard_ctrl: each task drives a cycle, queues the expected output
// vector, and compares it at the falling edge of the same cycle.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e;
  logic [4:0] destinationReg_e, destinationReg_m, destinationReg_w;
  logic       memRead_e, pcSrc_e, regWrite_m, memAccess_m, regWrite_w, dmem_ready;
  logic       stall_f, stall_d, stall_x, flush_d, flush_e, flush_w;
  logic [1:0] forwardA_e, forwardB_e;
  logic       dmem_req, mem_err;

  int errors = 0;
  int checks = 0;

  logic [11:0] sb_v[$];
  string       sb_n[$];

  hazard_ctrl #(.MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .destinationReg_e(destinationReg_e), .memRead_e(memRead_e), .pcSrc_e(pcSrc_e),
    .destinationReg_m(destinationReg_m), .regWrite_m(regWrite_m), .memAccess_m(memAccess_m),
    .destinationReg_w(destinationReg_w), .regWrite_w(regWrite_w), .dmem_ready(dmem_ready),
    .stall_f(stall_f), .stall_d(stall_d), .stall_x(stall_x),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .forwardA_e(forwardA_e), .forwardB_e(forwardB_e),
    .dmem_req(dmem_req), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] mk(input logic sf, input logic sd, input logic sx,
                                     input logic fd, input logic fe, input logic fw,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input logic rq, input logic er);
    return {sf, sd, sx, fd, fe, fw, fa, fb, rq, er};
  endfunction

  function automatic logic [11:0] obs();
    return {stall_f, stall_d, stall_x, flush_d, flush_e, flush_w,
            forwardA_e, forwardB_e, dmem_req, mem_err};
  endfunction

  task automatic clear_inputs();
    rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0;
    destinationReg_e = 5'd0; destinationReg_m = 5'd0; destinationReg_w = 5'd0;
    memRead_e = 1'b0; pcSrc_e = 1'b0; regWrite_m = 1'b0; memAccess_m = 1'b0;
    regWrite_w = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] ev;
    string en;
    logic [1:0] st;
    next_cycle();
    rst = 1'b1;
    memAccess_m = 1'b1; dmem_ready = 1'b0;
    memRead_e = 1'b1; destinationReg_e = 5'd3; rs1_d = 5'd3;
    regWrite_m = 1'b1; destinationReg_m = 5'd4; rs1_e = 5'd4;
    sb_v.push_back(mk(0,0,0,1,1,1,2'b00,2'b00,0,0)); sb_n.push_back("reset_outputs");
    @(negedge clk);
    ev = sb_v.pop_front(); en = sb_n.pop_front();
    checks++;
    if (obs() !== ev) begin errors++; $display("FAIL %s: got %b want %b", en, obs(), ev); end
    next_cycle();
    rst = 1'b0;
    clear_inputs();
    sb_v.push_back(mk(0,0,0,0,0,0,2'b00,2'b00,0,0)); sb_n.push_back("after_reset_idle");
    @(negedge clk);
    ev = sb_v.pop_front(); en = sb_n.pop_front();
    checks++;
    if (obs() !== ev) begin errors++; $display("FAIL %s: got %b want %b", en, obs(), ev); end
    st = dut.state_q;
    checks++;
    if (st !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", st); end
  endtask

  task automatic test_forward();
    logic [11:0] ev;
    string en;
    logic [4:0] t_rdm [6] = '{5'd5, 5'd0, 5'd5, 5'd3, 5'd0, 5'd4};
    logic       t_rwm [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [4:0] t_rdw [6] = '{5'd5, 5'd0, 5'd5, 5'd9, 5'd0, 5'd12};
    logic       t_rww [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [4:0] t_r1  [6] = '{5'd5, 5'd5, 5'd5, 5'd9, 5'd0, 5'd12};
    logic [4:0] t_r2  [6] = '{5'd5, 5'd5, 5'd9, 5'd3, 5'd0, 5'd4};
    logic [1:0] t_fa  [6] = '{2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    logic [1:0] t_fb  [6] = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10};
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      clear_inputs();
      destinationReg_m = t_rdm[i]; regWrite_m = t_rwm[i];
      destinationReg_w = t_rdw[i]; regWrite_w = t_rww[i];
      rs1_e = t_r1[i]; rs2_e = t_r2[i];
      sb_v.push_back(mk(0,0,0,0,0,0,t_fa[i],t_fb[i],0,0));
      sb_n.push_back($sformatf("forward_case%0d", i));
      @(negedge clk);
      ev = sb_v.pop_front(); en = sb_n.pop_front();
      checks++;
      if (obs() !== ev) begin errors++; $display("FAIL %s: got %b want %b", en, obs(), ev); end
    end
  endtask

  task automatic test_load_use();
    logic [11:0] ev;
    string en;
    logic       t_mr [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [4:0] t_rd [5] = '{5'd7, 5'd7, 5'd0, 5'd8, 5'd8};
    logic [4:0] t_s1 [5] = '{5'd3, 5'd3, 5'd0, 5'd8, 5'd2};
    logic [4:0] t_s2 [5] = '{5'd7, 5'd7, 5'd6, 5'd1, 5'd3};
    logic       t_lu [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      clear_inputs();
      memRead_e = t_mr[i]; destinationReg_e = t_rd[i];
      rs1_d = t_s1[i]; rs2_d = t_s2[i];
      sb_v.push_back(mk(t_lu[i],t_lu[i],0,0,t_lu[i],0,2'b00,2'b00,0,0));
      sb_n.push_back($sformatf("load_use_step%0d", i));
      @(negedge clk);
      ev = sb_v.pop_front(); en = sb_n.pop_front();
      checks++;
      if (obs() !== ev) begin errors++; $display("FAIL %s: got %b want %b", en, obs(), ev); end
    end
  endtask

  task automatic test_branch();
    logic [11:0] ev;
    string en;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      clear_inputs();
      pcSrc_e = 1'b1;
      if (i == 0) begin
        memRead_e = 1'b1; destinationReg_e = 5'd7; rs2_d = 5'd7;
      end
      sb_v.push_back(mk(0,0,0,1,1,0,2'b00,2'b00,0,0));
      sb_n.push_back(i == 0 ? "branch_over_load_use" : "branch_alone");
      @(negedge clk);
      ev = sb_v.pop_front(); en = sb_n.pop_front();
      checks++;
      if (obs() !== ev) begin errors++; $display("FAIL %s: got %b want %b", en, obs(), ev); end
    end
  endtask

  task automatic test_mem_wait();
    logic [11:0] ev;
    string en;
    logic [1:0] st;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      clear_inputs();
      memAccess_m = (i < 4) || (i == 5);
      dmem_ready  = (i >= 3);
      if (i < 3)       sb_v.push_back(mk(1,1,1,0,0,1,2'b00,2'b00,1,0));
      else if (i == 4) sb_v.push_back(mk(0,0,0,0,0,0,2'b00,2'b00,0,0));
      else             sb_v.push_back(mk(0,0,0,0,0,0,2'b00,2'b00,1,0));
      sb_n.push_back($sformatf("mem_wait_cycle%0d", i));
      @(negedge clk);
      ev = sb_v.pop_front(); en = sb_n.pop_front();
      checks++;
      if (obs() !== ev) begin errors++; $display("FAIL %s: got %b want %b", en, obs(), ev); end
      if (i == 4) begin
        st = dut.state_q;
        checks++;
        if (st !== 2'd0) begin errors++; $display("FAIL mem_wait_release_state: got %0d want 0", st); end
      end
    end
  endtask

  task automatic test_branch_during_stall();
    logic [11:0] ev;
    string en;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      clear_inputs();
      memAccess_m = (i < 3);
      dmem_ready  = (i == 2);
      pcSrc_e     = (i < 3);
      if (i < 2)       sb_v.push_back(mk(1,1,1,0,0,1,2'b00,2'b00,1,0));
      else if (i == 2) sb_v.push_back(mk(0,0,0,1,1,0,2'b00,2'b00,1,0));
      else             sb_v.push_back(mk(0,0,0,0,0,0,2'b00,2'b00,0,0));
      sb_n.push_back($sformatf("branch_in_stall%0d", i));
      @(negedge clk);
      ev = sb_v.pop_front(); en = sb_n.pop_front();
      checks++;
      if (obs() !== ev) begin errors++; $display("FAIL %s: got %b want %b", en, obs(), ev); end
    end
  endtask

  task automatic test_rst_in_wait();
    logic [11:0] ev;
    string en;
    logic [1:0] st;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      clear_inputs();
      memAccess_m = 1'b1;
      dmem_ready  = (i == 3);
      rst         = (i == 2);
      if (i < 2)       sb_v.push_back(mk(1,1,1,0,0,1,2'b00,2'b00,1,0));
      else if (i == 2) sb_v.push_back(mk(0,0,0,1,1,1,2'b00,2'b00,0,0));
      else             sb_v.push_back(mk(0,0,0,0,0,0,2'b00,2'b00,1,0));
      sb_n.push_back($sformatf("rst_in_wait%0d", i));
      @(negedge clk);
      ev = sb_v.pop_front(); en = sb_n.pop_front();
      checks++;
      if (obs() !== ev) begin errors++; $display("FAIL %s: got %b want %b", en, obs(), ev); end
      if (i == 3) begin
        st = dut.state_q;
        checks++;
        if (st !== 2'd0) begin errors++; $display("FAIL rst_in_wait_state: got %0d want 0", st); end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_timeout();
    logic [11:0] ev;
    string en;
    logic [1:0] st;
    // 5 stalls, 1 idle (counter clears), 8 stalls, 4 cycles ERROR, 1 reset, 1 idle
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      clear_inputs();
      rst         = (i == 18);
      memAccess_m = (i != 5) && (i != 19);
      dmem_ready  = (i >= 17) && (i < 18);
      if (i < 5)       sb_v.push_back(mk(1,1,1,0,0,1,2'b00,2'b00,1,0));
      else if (i == 5) sb_v.push_back(mk(0,0,0,0,0,0,2'b00,2'b00,0,0));
      else if (i < 14) sb_v.push_back(mk(1,1,1,0,0,1,2'b00,2'b00,1,0));
      else if (i < 18) sb_v.push_back(mk(1,1,1,0,0,1,2'b00,2'b00,0,1));
      else if (i == 18) sb_v.push_back(mk(0,0,0,1,1,1,2'b00,2'b00,0,1));
      else             sb_v.push_back(mk(0,0,0,0,0,0,2'b00,2'b00,0,0));
      sb_n.push_back($sformatf("timeout_cycle%0d", i));
      @(negedge clk);
      ev = sb_v.pop_front(); en = sb_n.pop_front();
      checks++;
      if (obs() !== ev) begin errors++; $display("FAIL %s: got %b want %b", en, obs(), ev); end
      if (i == 14 || i == 19) begin
        st = dut.state_q;
        checks++;
        if (st !== ((i == 14) ? 2'd2 : 2'd0)) begin
          errors++;
          $display("FAIL timeout_state_cycle%0d: got %0d want %0d", i, st, (i == 14) ? 2 : 0);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_branch_during_stall();
    test_rst_in_wait();
    test_timeout();
    if (sb_v.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover want 0", sb_v.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
